spi_master_multimode: RTL and testbench
=======================================

SPI_MASTER_MULTIMODE -- requirements
Module: spi_master_multimode

Interface
REQ-001 Parameters: DATA_WIDTH, default 8, word length in bits; N_SLAVES, default 4, slave-select lines; DIV_WIDTH, default 8, clock-divider register width.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 fifo_req_data  out  1  one-cycle pop request to TX FIFO.
REQ-005 fifo_din  in  DATA_WIDTH  TX word; fifo_din_valid  in  1  word valid; fifo_empty  in  1  FIFO empty.
REQ-006 spi_slave_addr  in  $clog2(N_SLAVES)+1  target slave index, sampled with each word.
REQ-007 reg_addr  in  2  register address; reg_din  in  DIV_WIDTH  write data; reg_din_val  in  1  write strobe.
REQ-008 reg_ack  out  1  write accepted; reg_err  out  1  write rejected.
REQ-009 busy  out  1  transfer in progress; dout  out  DATA_WIDTH  RX word; dout_valid  out  1  one-cycle RX strobe.
REQ-010 spi_clk  out  1; spi_mosi  out  1; spi_miso  in  1; spi_ss  out  N_SLAVES, active-low.

Function
REQ-011 Registers: addr 0 DIV (reset 1); addr 1 MODE bits [0]=CPHA, [1]=CPOL, [2]=LSB_FIRST (reset 0); addr 2 BURST bit [0] (reset 0); addr 3 reserved.
REQ-012 Write with reg_din_val=1, busy=0, addr 0..2: register updates, reg_ack=1 next cycle for one cycle.
REQ-013 Write while busy=1 or to addr 3: no update, reg_err=1 next cycle for one cycle; DIV write of 0 forced to 1.
REQ-014 spi_clk half-period = DIV+1 clk cycles; idle level = CPOL.
REQ-015 FSM states: IDLE, REQ, WAIT_DATA, SS_SETUP, SHIFT, SS_HOLD.
REQ-016 IDLE -> REQ when fifo_empty=0; REQ drives fifo_req_data=1 for exactly one cycle, -> WAIT_DATA.
REQ-017 WAIT_DATA: on fifo_din_valid=1 latch fifo_din and spi_slave_addr, -> SS_SETUP; busy=1 from REQ until return to IDLE.
REQ-018 Latched address >= N_SLAVES: word discarded, no SS asserted, no dout_valid, -> IDLE.
REQ-019 SS_SETUP: assert selected spi_ss low, wait one half-period, -> SHIFT; CPHA=0 drives first MOSI bit on SS assertion.
REQ-020 SHIFT: DATA_WIDTH spi_clk periods; CPHA=0 samples MISO on leading edge, shifts MOSI on trailing edge; CPHA=1 shifts on leading, samples on trailing.
REQ-021 Bit order MSB first unless LSB_FIRST=1; dout uses same order.
REQ-022 After final sampling edge: dout updated and dout_valid=1 for one cycle, -> SS_HOLD.
REQ-023 SS_HOLD: if BURST=1, fifo_empty=0 and next address equals current, -> REQ keeping SS low; else one half-period with spi_clk at CPOL, release SS, -> IDLE.
REQ-024 MODE/DIV changes apply only from IDLE; spi_mosi idles low.
REQ-025 fifo_din_valid outside WAIT_DATA is ignored.

Reset
REQ-026 rst=0 immediately forces IDLE, spi_ss all ones, spi_clk=0, spi_mosi=0, fifo_req_data=0, busy=0, dout=0, dout_valid=0, reg_ack=0, reg_err=0, registers to reset values.
REQ-027 Reset mid-transfer discards the partial word; no dout_valid produced.

Structure
REQ-028 Package spi_master_pkg holds state enum, register-address constants, MODE bit-index constants.
REQ-029 Sub-module spi_clk_gen: divider counter producing spi_clk plus one-cycle leading/trailing edge strobes, enabled by FSM.
REQ-030 Target 200-350 RTL lines; no latches; single clock domain (spi_miso sampled directly).

Verification
REQ-031 Reset defaults, DIV=1, mode 0, word 0xA5 to slave 2, slave echoes 0x3C -> MOSI 10100101, spi_ss=4'b1011 during shift, dout=0x3C, one dout_valid, 8 spi_clk periods of 4 clk each.
REQ-032 MODE=3 (CPOL=1,CPHA=1), LSB_FIRST=1, word 0x01 -> spi_clk idles high, MOSI first bit 1, dout bit-reversed relative to MISO order.
REQ-033 BURST=1, three words to slave 0 queued -> SS low continuously across 24 bits, three dout_valid pulses; BURST=0 -> SS released between words.
REQ-034 DIV write during busy -> reg_err pulse, DIV unchanged; write addr 3 -> reg_err; DIV=0 write -> reads effective half-period 2 clk.
REQ-035 spi_slave_addr=5 with N_SLAVES=4 -> word popped, spi_ss stays 4'b1111, no dout_valid, busy returns low.
REQ-036 rst asserted at bit 4 of a transfer -> all outputs at reset values same cycle, next word transfers correctly after release.

Source files
------------

// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared constants for the multi-mode SPI master
package spi_master_pkg;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_REQ       = 3'd1;
   localparam logic [2:0] ST_WAIT_DATA = 3'd2;
   localparam logic [2:0] ST_SS_SETUP  = 3'd3;
   localparam logic [2:0] ST_SHIFT     = 3'd4;
   localparam logic [2:0] ST_SS_HOLD   = 3'd5;

   // Register addresses
   localparam logic [1:0] REG_DIV   = 2'd0;
   localparam logic [1:0] REG_MODE  = 2'd1;
   localparam logic [1:0] REG_BURST = 2'd2;
   localparam logic [1:0] REG_RSVD  = 2'd3;

   // MODE register bit positions
   localparam int MODE_CPHA = 0;
   localparam int MODE_CPOL = 1;
   localparam int MODE_LSB  = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period divider producing spi_clk and edge strobes
module spi_clk_gen #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 toggle,
   input  logic                 cpol,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 spi_clk,
   output logic                 tick,
   output logic                 lead,
   output logic                 trail
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 spi_clk_q, spi_clk_d;

   // tick marks the last clk cycle of each half-period (DIV+1 cycles long)
   always_comb begin
      tick      = run && (cnt_q == div);
      lead      = tick && toggle && (spi_clk_q == cpol);
      trail     = tick && toggle && (spi_clk_q != cpol);
      cnt_d     = (!run || tick) ? '0 : cnt_q + 1'b1;
      spi_clk_d = toggle ? (tick ? ~spi_clk_q : spi_clk_q) : cpol;
   end

   // Divider counter and spi_clk register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         spi_clk_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         spi_clk_q <= spi_clk_d;
      end
   end

   assign spi_clk = spi_clk_q;

endmodule

// File: rtl/spi_master_multimode.sv
// rtl/spi_master_multimode.sv - FIFO-fed SPI master with CPOL/CPHA/LSB/burst modes
module spi_master_multimode
   import spi_master_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int N_SLAVES   = 4,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      fifo_req_data,
   input  logic [DATA_WIDTH-1:0]     fifo_din,
   input  logic                      fifo_din_valid,
   input  logic                      fifo_empty,
   input  logic [$clog2(N_SLAVES):0] spi_slave_addr,
   input  logic [1:0]                reg_addr,
   input  logic [DIV_WIDTH-1:0]      reg_din,
   input  logic                      reg_din_val,
   output logic                      reg_ack,
   output logic                      reg_err,
   output logic                      busy,
   output logic [DATA_WIDTH-1:0]     dout,
   output logic                      dout_valid,
   output logic                      spi_clk,
   output logic                      spi_mosi,
   input  logic                      spi_miso,
   output logic [N_SLAVES-1:0]       spi_ss
);

   localparam int AW = $clog2(N_SLAVES) + 1;
   localparam int EW = $clog2(2 * DATA_WIDTH) + 1;
   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam logic [AW-1:0]       N_SLV     = AW'(N_SLAVES);
   localparam logic [EW-1:0]       LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
   localparam logic [BW-1:0]       LAST_BIT  = BW'(DATA_WIDTH - 1);
   localparam logic [N_SLAVES-1:0] SS_ONE    = {{(N_SLAVES-1){1'b0}}, 1'b1};

   logic [2:0]            state_q, state_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [2:0]            mode_q, mode_d;
   logic                  burst_q, burst_d;
   logic                  reg_ack_q, reg_ack_d, reg_err_q, reg_err_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  mosi_q, mosi_d;
   logic [N_SLAVES-1:0]   ss_q, ss_d;
   logic [EW-1:0]         edge_q, edge_d;
   logic [BW-1:0]         bit_q, bit_d;

   logic cpha, cpol, lsb, tick, lead, trail, shift_ev, samp_ev, reg_wr_ok;
   logic [DATA_WIDTH-1:0] rx_next;

   assign cpha = mode_q[MODE_CPHA];
   assign cpol = mode_q[MODE_CPOL];
   assign lsb  = mode_q[MODE_LSB];

   spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
      .clk    (clk),
      .rst    (rst),
      .run    ((state_q == ST_SS_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_SS_HOLD)),
      .toggle (state_q == ST_SHIFT),
      .cpol   (cpol),
      .div    (div_q),
      .spi_clk(spi_clk),
      .tick   (tick),
      .lead   (lead),
      .trail  (trail)
   );

   // Register writes and the transfer FSM with its shift/sample datapath
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      mode_d       = mode_q;
      burst_d      = burst_q;
      addr_d       = addr_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      mosi_d       = mosi_q;
      ss_d         = ss_q;
      edge_d       = edge_q;
      bit_d        = bit_q;

      // Config only changes while idle, so an active transfer never sees it move
      reg_wr_ok = reg_din_val && !busy && (reg_addr != REG_RSVD);
      reg_ack_d = reg_wr_ok;
      reg_err_d = reg_din_val && !reg_wr_ok;
      if (reg_wr_ok) begin
         case (reg_addr)
            REG_DIV:   div_d   = (reg_din == '0) ? DIV_WIDTH'(1) : reg_din;
            REG_MODE:  mode_d  = reg_din[2:0];
            REG_BURST: burst_d = reg_din[0];
            default:   ;
         endcase
      end

      // CPHA=0 drives on trailing and samples on leading; CPHA=1 is the reverse
      shift_ev = cpha ? lead : trail;
      samp_ev  = cpha ? trail : lead;
      rx_next  = lsb ? {spi_miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], spi_miso};

      case (state_q)
         ST_IDLE: begin
            mosi_d = 1'b0;
            if (!fifo_empty) state_d = ST_REQ;
         end
         ST_REQ: state_d = ST_WAIT_DATA;
         ST_WAIT_DATA: begin
            if (fifo_din_valid) begin
               if (spi_slave_addr >= N_SLV) begin
                  ss_d    = '1;
                  state_d = ST_IDLE;
               end else begin
                  addr_d  = spi_slave_addr;
                  ss_d    = ~(SS_ONE << spi_slave_addr);
                  edge_d  = '0;
                  bit_d   = '0;
                  state_d = ST_SS_SETUP;
                  // CPHA=0 puts the first bit out with SS; CPHA=1 waits for the leading edge
                  if (cpha) begin
                     tx_d   = fifo_din;
                     mosi_d = 1'b0;
                  end else begin
                     mosi_d = lsb ? fifo_din[0] : fifo_din[DATA_WIDTH-1];
                     tx_d   = lsb ? (fifo_din >> 1) : (fifo_din << 1);
                  end
               end
            end
         end
         ST_SS_SETUP: if (tick) state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (shift_ev) begin
               mosi_d = lsb ? tx_q[0] : tx_q[DATA_WIDTH-1];
               tx_d   = lsb ? (tx_q >> 1) : (tx_q << 1);
            end
            if (samp_ev) begin
               rx_d  = rx_next;
               bit_d = bit_q + 1'b1;
               if (bit_q == LAST_BIT) begin
                  dout_d       = rx_next;
                  dout_valid_d = 1'b1;
               end
            end
            // Leave only after the full last period so spi_clk is back at CPOL
            if (tick) begin
               edge_d = edge_q + 1'b1;
               if (edge_q == LAST_EDGE) state_d = ST_SS_HOLD;
            end
         end
         ST_SS_HOLD: begin
            if (burst_q && !fifo_empty && (spi_slave_addr == addr_q)) begin
               state_d = ST_REQ;
            end else if (tick) begin
               ss_d    = '1;
               mosi_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         div_q        <= DIV_WIDTH'(1);
         mode_q       <= '0;
         burst_q      <= 1'b0;
         reg_ack_q    <= 1'b0;
         reg_err_q    <= 1'b0;
         addr_q       <= '0;
         tx_q         <= '0;
         rx_q         <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         mosi_q       <= 1'b0;
         ss_q         <= '1;
         edge_q       <= '0;
         bit_q        <= '0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         mode_q       <= mode_d;
         burst_q      <= burst_d;
         reg_ack_q    <= reg_ack_d;
         reg_err_q    <= reg_err_d;
         addr_q       <= addr_d;
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         mosi_q       <= mosi_d;
         ss_q         <= ss_d;
         edge_q       <= edge_d;
         bit_q        <= bit_d;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign fifo_req_data = (state_q == ST_REQ);
   assign reg_ack       = reg_ack_q;
   assign reg_err       = reg_err_q;
   assign dout          = dout_q;
   assign dout_valid    = dout_valid_q;
   assign spi_mosi      = mosi_q;
   assign spi_ss        = ss_q;

endmodule

// File: tb/tb_spi_master_multimode.sv
// tb/tb_spi_master_multimode.sv - directed self-checking bench for spi_master_multimode
module tb_spi_master_multimode;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_req_data;
   logic [7:0] fifo_din = '0;
   logic       fifo_din_valid = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [2:0] spi_slave_addr = '0;
   logic [1:0] reg_addr;
   logic [7:0] reg_din;
   logic       reg_din_val;
   logic       reg_ack, reg_err, busy;
   logic [7:0] dout;
   logic       dout_valid;
   logic       spi_clk, spi_mosi;
   logic       spi_miso = 1'b0;
   logic [3:0] spi_ss;

   int checks = 0;
   int errors = 0;

   // FIFO model: initial block fills, responder drains
   logic [7:0] word_mem [64];
   logic [2:0] addr_mem [64];
   int   wr_ptr = 0;
   int   rd_ptr = 0;
   logic pend = 1'b0;
   int   req_cnt = 0;

   // Slave model and monitors
   logic       slv_cpol = 1'b0, slv_cpha = 1'b0;
   logic [7:0] slv_tx = '0;
   logic [7:0] slv_rx = '0;
   logic       ss_active = 1'b0, prev_sclk = 1'b0, lead;
   int         slv_idx = 0, cyc = 0, last_lead = 0, lead_period = 0;
   int         lead_cnt = 0, dv_cnt = 0, ss_rel_cnt = 0, ss_low_cyc = 0;
   logic [7:0] last_dout = '0;
   logic [3:0] ss_seen = '1;

   always #5 clk = ~clk;

   spi_master_multimode #(.DATA_WIDTH(8), .N_SLAVES(4), .DIV_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .fifo_req_data(fifo_req_data), .fifo_din(fifo_din),
      .fifo_din_valid(fifo_din_valid), .fifo_empty(fifo_empty), .spi_slave_addr(spi_slave_addr),
      .reg_addr(reg_addr), .reg_din(reg_din), .reg_din_val(reg_din_val), .reg_ack(reg_ack),
      .reg_err(reg_err), .busy(busy), .dout(dout), .dout_valid(dout_valid), .spi_clk(spi_clk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss(spi_ss)
   );

   // FIFO responder: answers a pop request with one valid word one cycle later
   always @(negedge clk) begin
      fifo_din_valid = 1'b0;
      if (!rst) begin
         pend = 1'b0;
      end else if (pend) begin
         fifo_din       = word_mem[rd_ptr % 64];
         spi_slave_addr = addr_mem[rd_ptr % 64];
         fifo_din_valid = 1'b1;
         rd_ptr++;
         pend = 1'b0;
      end else if (rd_ptr != wr_ptr) begin
         spi_slave_addr = addr_mem[rd_ptr % 64];
      end
      if (fifo_req_data) begin
         req_cnt++;
         if (rd_ptr != wr_ptr) pend = 1'b1;
      end
      fifo_empty = (rd_ptr == wr_ptr);
   end

   // SPI slave: echoes slv_tx MSB-first on the wire, records MOSI in wire order
   always @(negedge clk) begin
      cyc++;
      if (dout_valid) begin
         dv_cnt++;
         last_dout = dout;
      end
      if (&spi_ss) begin
         if (ss_active) ss_rel_cnt++;
         ss_active = 1'b0;
      end else begin
         ss_low_cyc++;
         if (!ss_active) begin
            ss_active = 1'b1;
            slv_idx   = 0;
            if (!slv_cpha) begin
               spi_miso = slv_tx[7];
               slv_idx  = 1;
            end
         end
         if (spi_clk != prev_sclk) begin
            lead = (spi_clk != slv_cpol);
            if (lead) begin
               lead_cnt++;
               lead_period = cyc - last_lead;
               last_lead   = cyc;
               ss_seen     = spi_ss;
            end
            if (lead != slv_cpha) begin
               slv_rx = {slv_rx[6:0], spi_mosi};
            end else begin
               spi_miso = slv_tx[7 - (slv_idx % 8)];
               slv_idx++;
            end
         end
      end
      prev_sclk = spi_clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] w, input logic [2:0] a);
      word_mem[wr_ptr % 64] = w;
      addr_mem[wr_ptr % 64] = a;
      wr_ptr++;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(rd_ptr == wr_ptr && !busy && !pend) && n < 3000) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s_timeout: busy=%0b rd=%0d wr=%0d required idle", name, busy, rd_ptr, wr_ptr);
      end
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [7:0] d, output logic ack, output logic err);
      reg_addr    = a;
      reg_din     = d;
      reg_din_val = 1'b1;
      tick();
      reg_din_val = 1'b0;
      ack = reg_ack;
      err = reg_err;
   endtask

   task automatic test_reset();
      rst = 1'b0; reg_addr = '0; reg_din = '0; reg_din_val = 1'b0;
      repeat (3) tick();
      checks++;
      if ({spi_ss, spi_clk, spi_mosi, busy, fifo_req_data, dout_valid, reg_ack, reg_err} !== 11'b1111_0000000) begin
         errors++;
         $display("FAIL reset_ctrl: got ss=%b clk=%b mosi=%b busy=%b req=%b dv=%b ack=%b err=%b required ss=1111 rest 0",
                  spi_ss, spi_clk, spi_mosi, busy, fifo_req_data, dout_valid, reg_ack, reg_err);
      end
      checks++;
      if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h required 00", dout); end
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0 || spi_ss !== 4'hF) begin
         errors++; $display("FAIL reset_idle: got busy=%b ss=%b required 0/1111", busy, spi_ss);
      end
   endtask

   task automatic test_mode0();
      int dv0, ld0, rq0;
      dv0 = dv_cnt; ld0 = lead_cnt; rq0 = req_cnt;
      slv_cpol = 0; slv_cpha = 0; slv_tx = 8'h3C;
      push(8'hA5, 3'd2);
      wait_done("mode0");
      checks++;
      if (slv_rx !== 8'hA5) begin errors++; $display("FAIL mode0_mosi: got %h required a5", slv_rx); end
      checks++;
      if (ss_seen !== 4'b1011) begin errors++; $display("FAIL mode0_ss: got %b required 1011", ss_seen); end
      checks++;
      if (dout !== 8'h3C) begin errors++; $display("FAIL mode0_dout: got %h required 3c", dout); end
      checks++;
      if (dv_cnt - dv0 != 1) begin errors++; $display("FAIL mode0_dv_count: got %0d required 1", dv_cnt - dv0); end
      checks++;
      if (lead_cnt - ld0 != 8) begin errors++; $display("FAIL mode0_periods: got %0d required 8", lead_cnt - ld0); end
      checks++;
      if (lead_period != 4) begin errors++; $display("FAIL mode0_period_len: got %0d required 4", lead_period); end
      checks++;
      if (req_cnt - rq0 != 1) begin errors++; $display("FAIL mode0_req_count: got %0d required 1", req_cnt - rq0); end
      checks++;
      if (spi_ss !== 4'hF || spi_mosi !== 1'b0) begin
         errors++; $display("FAIL mode0_idle: got ss=%b mosi=%b required 1111/0", spi_ss, spi_mosi);
      end
   endtask

   task automatic test_mode3_lsb();
      logic ack, err;
      reg_write(2'd1, 8'h07, ack, err);
      checks++;
      if (ack !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL mode3_write: got ack=%b err=%b required 1/0", ack, err);
      end
      tick();
      checks++;
      if (reg_ack !== 1'b0) begin errors++; $display("FAIL mode3_ack_pulse: got %b required 0", reg_ack); end
      checks++;
      if (spi_clk !== 1'b1) begin errors++; $display("FAIL mode3_idle_clk: got %b required 1", spi_clk); end
      slv_cpol = 1; slv_cpha = 1; slv_tx = 8'hC5;
      push(8'h01, 3'd1);
      wait_done("mode3");
      checks++;
      if (slv_rx !== 8'h80) begin errors++; $display("FAIL mode3_mosi: got %h required 80", slv_rx); end
      checks++;
      if (dout !== 8'hA3) begin errors++; $display("FAIL mode3_dout: got %h required a3", dout); end
      checks++;
      if (spi_clk !== 1'b1) begin errors++; $display("FAIL mode3_end_clk: got %b required 1", spi_clk); end
      reg_write(2'd1, 8'h00, ack, err);
      tick();
      slv_cpol = 0; slv_cpha = 0;
   endtask

   task automatic test_burst();
      logic ack, err;
      int dv0, ld0, rl0;
      reg_write(2'd2, 8'h01, ack, err);
      tick();
      dv0 = dv_cnt; ld0 = lead_cnt; rl0 = ss_rel_cnt;
      slv_tx = 8'h5A;
      push(8'h11, 3'd0); push(8'h22, 3'd0); push(8'h33, 3'd0);
      wait_done("burst");
      checks++;
      if (dv_cnt - dv0 != 3) begin errors++; $display("FAIL burst_dv_count: got %0d required 3", dv_cnt - dv0); end
      checks++;
      if (ss_rel_cnt - rl0 != 1) begin errors++; $display("FAIL burst_ss_releases: got %0d required 1", ss_rel_cnt - rl0); end
      checks++;
      if (lead_cnt - ld0 != 24) begin errors++; $display("FAIL burst_bits: got %0d required 24", lead_cnt - ld0); end
      checks++;
      if (slv_rx !== 8'h33 || last_dout !== 8'h5A) begin
         errors++; $display("FAIL burst_data: got mosi=%h dout=%h required 33/5a", slv_rx, last_dout);
      end
      reg_write(2'd2, 8'h00, ack, err);
      tick();
      dv0 = dv_cnt; rl0 = ss_rel_cnt;
      push(8'h44, 3'd0); push(8'h55, 3'd0);
      wait_done("noburst");
      checks++;
      if (ss_rel_cnt - rl0 != 2 || dv_cnt - dv0 != 2) begin
         errors++; $display("FAIL noburst_release: got rel=%0d dv=%0d required 2/2", ss_rel_cnt - rl0, dv_cnt - dv0);
      end
   endtask

   task automatic test_regs();
      logic ack, err;
      int n;
      slv_tx = 8'h69;
      push(8'h0F, 3'd1);
      n = 0;
      while (!busy && n < 50) begin tick(); n++; end
      reg_write(2'd0, 8'h05, ack, err);
      checks++;
      if (err !== 1'b1 || ack !== 1'b0) begin
         errors++; $display("FAIL busy_write: got ack=%b err=%b required 0/1", ack, err);
      end
      tick();
      checks++;
      if (reg_err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b required 0", reg_err); end
      wait_done("busy_write");
      checks++;
      if (lead_period != 4) begin errors++; $display("FAIL div_unchanged: got period %0d required 4", lead_period); end
      reg_write(2'd3, 8'h01, ack, err);
      checks++;
      if (err !== 1'b1 || ack !== 1'b0) begin
         errors++; $display("FAIL rsvd_write: got ack=%b err=%b required 0/1", ack, err);
      end
      reg_write(2'd0, 8'h03, ack, err);
      push(8'hF0, 3'd3);
      wait_done("div3");
      checks++;
      if (lead_period != 8) begin errors++; $display("FAIL div3_period: got %0d required 8", lead_period); end
      reg_write(2'd0, 8'h00, ack, err);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("FAIL div0_ack: got %b required 1", ack); end
      push(8'hF0, 3'd3);
      wait_done("div0");
      checks++;
      if (lead_period != 4) begin errors++; $display("FAIL div0_period: got %0d required 4", lead_period); end
      reg_write(2'd0, 8'h03, ack, err);
      tick();
   endtask

   task automatic test_bad_addr();
      int dv0, rq0, sl0;
      dv0 = dv_cnt; rq0 = req_cnt; sl0 = ss_low_cyc;
      push(8'h77, 3'd5);
      wait_done("bad_addr");
      checks++;
      if (req_cnt - rq0 != 1) begin errors++; $display("FAIL bad_addr_pop: got %0d required 1", req_cnt - rq0); end
      checks++;
      if (ss_low_cyc != sl0 || dv_cnt != dv0) begin
         errors++; $display("FAIL bad_addr_quiet: got ss_low=%0d dv=%0d required 0/0", ss_low_cyc - sl0, dv_cnt - dv0);
      end
      checks++;
      if (busy !== 1'b0 || spi_ss !== 4'hF) begin
         errors++; $display("FAIL bad_addr_idle: got busy=%b ss=%b required 0/1111", busy, spi_ss);
      end
   endtask

   task automatic test_reset_mid();
      int ld0, dv0, n;
      slv_tx = 8'hE1;
      ld0 = lead_cnt; dv0 = dv_cnt;
      push(8'h96, 3'd3);
      n = 0;
      while (lead_cnt - ld0 < 4 && n < 500) begin tick(); n++; end
      checks++;
      if (n >= 500) begin errors++; $display("FAIL rstmid_reach: got %0d edges required 4", lead_cnt - ld0); end
      rst = 1'b0;
      #1;
      checks++;
      if ({spi_ss, spi_clk, spi_mosi, busy, fifo_req_data, dout_valid, reg_ack, reg_err} !== 11'b1111_0000000 ||
          dout !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_outputs: got ss=%b clk=%b mosi=%b busy=%b dout=%h dv=%b required reset values",
                  spi_ss, spi_clk, spi_mosi, busy, dout, dout_valid);
      end
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if (dv_cnt != dv0) begin errors++; $display("FAIL rstmid_no_dv: got %0d pulses required 0", dv_cnt - dv0); end
      dv0 = dv_cnt;
      push(8'h4B, 3'd3);
      wait_done("rstmid_next");
      checks++;
      if (slv_rx !== 8'h4B || dout !== 8'hE1 || ss_seen !== 4'b0111 || dv_cnt - dv0 != 1) begin
         errors++;
         $display("FAIL rstmid_next: got mosi=%h dout=%h ss=%b dv=%0d required 4b/e1/0111/1",
                  slv_rx, dout, ss_seen, dv_cnt - dv0);
      end
      checks++;
      if (lead_period != 4) begin errors++; $display("FAIL rstmid_div: got period %0d required 4", lead_period); end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3_lsb();
      test_burst();
      test_regs();
      test_bad_addr();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
